// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_pkg
// Brief    : Shared RV32M funct3 codes, sequencer state encodings and decode helpers.
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_CALC = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic is_rem(input logic [2:0] f3);
        return f3[2] & f3[1];
    endfunction

    function automatic logic a_is_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_step
// Brief    : One radix-2 iteration: shift-add multiply or restoring divide.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              mode,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN-1:0] acc_next,
    output logic              qbit
);
    logic [XLEN:0] w_mul_sum;
    logic [XLEN:0] w_div_rem;
    logic [XLEN:0] w_div_diff;

    // Multiply: acc = {product high, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, dividend bits then quotient bits};
    // the quotient bit slot is left zero and merged by the caller from qbit.
    always_comb begin
        w_mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
        w_div_rem  = acc[2*XLEN-1:XLEN-1];
        w_div_diff = w_div_rem - {1'b0, operand};
        qbit       = 1'b0;
        acc_next   = {w_mul_sum, acc[XLEN-1:1]};
        if (mode) begin
            qbit     = ~w_div_diff[XLEN];
            acc_next = qbit ? {w_div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                            : {w_div_rem[XLEN-1:0],  acc[XLEN-2:0], 1'b0};
        end
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sequencer
// Brief    : Multi-cycle RV32M multiply/divide sequencer with busy stall and done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam logic [CNT_W-1:0] c_iters   = CNT_W'(XLEN);
    localparam logic [XLEN-1:0]  c_int_min = {1'b1, {(XLEN-1){1'b0}}};

    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_counter;
    logic [2:0]        r_funct3;
    logic [XLEN-1:0]   r_op_a;
    logic [XLEN-1:0]   r_op_b;
    logic              r_sign_a;
    logic              r_sign_b;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_operand;
    logic              r_busy;
    logic              r_done;
    logic [XLEN-1:0]   r_result;

    logic              w_sa;
    logic              w_sb;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic              w_special;
    logic [XLEN-1:0]   w_special_res;
    logic [2*XLEN-1:0] w_step_acc;
    logic              w_step_q;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_fix_res;

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .mode     (is_div(r_funct3)),
        .acc      (r_acc),
        .operand  (r_operand),
        .acc_next (w_step_acc),
        .qbit     (w_step_q)
    );

    always_comb begin
        w_sa          = a_is_signed(r_funct3) & r_op_a[XLEN-1];
        w_sb          = b_is_signed(r_funct3) & r_op_b[XLEN-1];
        w_abs_a       = w_sa ? -r_op_a : r_op_a;
        w_abs_b       = w_sb ? -r_op_b : r_op_b;
        w_special     = 1'b0;
        w_special_res = '0;
        if (is_div(r_funct3)) begin
            if (r_op_b == '0) begin
                w_special     = 1'b1;
                w_special_res = is_rem(r_funct3) ? r_op_a : '1;
            end else if (b_is_signed(r_funct3) && r_op_a == c_int_min && r_op_b == '1) begin
                w_special     = 1'b1;
                w_special_res = is_rem(r_funct3) ? '0 : c_int_min;
            end
        end
    end

    // Sign correction: quotient and product follow sign_a^sign_b, remainder follows the dividend.
    always_comb begin
        w_prod    = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;
        w_quot    = (r_sign_a ^ r_sign_b) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
        w_rem     = r_sign_a ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
        w_fix_res = w_prod[2*XLEN-1:XLEN];
        case (r_funct3)
            F3_MUL:           w_fix_res = w_prod[XLEN-1:0];
            F3_DIV, F3_DIVU:  w_fix_res = w_quot;
            F3_REM, F3_REMU:  w_fix_res = w_rem;
            default:          w_fix_res = w_prod[2*XLEN-1:XLEN];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_counter <= '0;
            r_funct3  <= '0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_sign_a  <= 1'b0;
            r_sign_b  <= 1'b0;
            r_acc     <= '0;
            r_operand <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= '0;
        end else if (flush && r_state != S_IDLE) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_funct3 <= funct3;
                        r_op_a   <= op_a;
                        r_op_b   <= op_b;
                        r_busy   <= 1'b1;
                        r_state  <= S_PREP;
                    end
                end
                S_PREP: begin
                    r_sign_a  <= w_sa;
                    r_sign_b  <= w_sb;
                    r_counter <= c_iters;
                    if (is_div(r_funct3)) begin
                        r_acc     <= {{XLEN{1'b0}}, w_abs_a};
                        r_operand <= w_abs_b;
                    end else begin
                        r_acc     <= {{XLEN{1'b0}}, w_abs_b};
                        r_operand <= w_abs_a;
                    end
                    if (w_special) begin
                        r_result <= w_special_res;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_acc     <= w_step_acc | {{(2*XLEN-1){1'b0}}, w_step_q};
                    r_counter <= r_counter - CNT_W'(1);
                    if (r_counter == CNT_W'(1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_result <= w_fix_res;
                    r_done   <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_sequencer
// Brief    : Self-checking bench for muldiv_sequencer against a plain-arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_muldiv_sequencer;

    localparam int XLEN    = 32;
    localparam int LAT     = XLEN + 3;
    localparam int LAT_SP  = 2;
    localparam int BUDGET  = 45;

    localparam int D_NONE  = 0;
    localparam int D_START = 1;
    localparam int D_FLUSH = 2;
    localparam int D_RESET = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            flush = 1'b0;
    logic [2:0]      funct3 = 3'd0;
    logic [XLEN-1:0] op_a = '0;
    logic [XLEN-1:0] op_b = '0;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .flush  (flush),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        int ia, ib;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        ia = a;
        ib = b;
        p  = '0;
        case (f3)
            3'b000: begin p = ua * ub; return p[31:0];  end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return ia / ib;
            end
            3'b101: begin
                if (b == 0) return 32'hFFFFFFFF;
                return a / b;
            end
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return ia % ib;
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && b == 0) return LAT_SP;
        if ((f3 == 3'b100 || f3 == 3'b110) && a == 32'h80000000 && b == 32'hFFFFFFFF) return LAT_SP;
        return LAT;
    endfunction

    // Launch one operation and observe it; an optional disturbance is applied in cycle dcyc.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input int dkind, input int dcyc,
                          output int lat, output logic [31:0] res, output bit busy_ok,
                          output logic busy_post, output logic [31:0] res_post,
                          output logic idle_busy, output logic idle_done);
        lat = 0; res = '0; busy_ok = 1'b1;
        busy_post = 1'b0; res_post = '0; idle_busy = 1'b0; idle_done = 1'b0;
        funct3 = f3; op_a = a; op_b = b; start = 1'b1;
        if (dcyc == 0 && dkind == D_FLUSH) flush = 1'b1;
        for (int c = 1; c <= BUDGET; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                start = 1'b0; funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
            end
            if (c == dcyc + 1) begin
                start = 1'b0; flush = 1'b0; reset = 1'b0;
                busy_post = busy; res_post = result;
            end
            if (c == dcyc && dkind != D_NONE) begin
                case (dkind)
                    D_START: begin
                        start = 1'b1; funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
                    end
                    D_FLUSH: flush = 1'b1;
                    default: reset = 1'b1;
                endcase
            end
            if (done) begin
                lat = c; res = result;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            res = result;
        end
        if (lat != 0) begin
            @(posedge clk); #1;
            start = 1'b0; flush = 1'b0; reset = 1'b0;
            idle_busy = busy; idle_done = done;
        end
        start = 1'b0; flush = 1'b0; reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if (result !== '0) begin n_err++; $display("FAIL reset_result: got %h expected 0", result); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic test_directed();
        vec_t tv[16];
        int lat; logic [31:0] res, rp; bit bok; logic bp, ib, id;
        tv[0]  = '{3'b000, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB};
        tv[1]  = '{3'b011, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE};
        tv[2]  = '{3'b001, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000};
        tv[3]  = '{3'b010, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF};
        tv[4]  = '{3'b000, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000001};
        tv[5]  = '{3'b100, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD};
        tv[6]  = '{3'b110, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF};
        tv[7]  = '{3'b101, 32'd100,        32'd7,        32'd14};
        tv[8]  = '{3'b111, 32'd100,        32'd7,        32'd2};
        tv[9]  = '{3'b101, 32'd5,          32'd0,        32'hFFFFFFFF};
        tv[10] = '{3'b110, 32'd5,          32'd0,        32'd5};
        tv[11] = '{3'b100, 32'h80000000,   32'hFFFFFFFF, 32'h80000000};
        tv[12] = '{3'b110, 32'h80000000,   32'hFFFFFFFF, 32'h00000000};
        tv[13] = '{3'b111, 32'd5,          32'd0,        32'd5};
        tv[14] = '{3'b100, 32'd5,          32'd0,        32'hFFFFFFFF};
        tv[15] = '{3'b101, 32'h80000000,   32'hFFFFFFFF, 32'h00000000};
        foreach (tv[i]) begin
            run_op(tv[i].f3, tv[i].a, tv[i].b, D_NONE, -5, lat, res, bok, bp, rp, ib, id);
            n_cmp++; if (res !== tv[i].exp) begin n_err++;
                $display("FAIL dir%0d_result f3=%b a=%h b=%h: got %h expected %h", i, tv[i].f3, tv[i].a, tv[i].b, res, tv[i].exp); end
            n_cmp++; if (lat != ref_lat(tv[i].f3, tv[i].a, tv[i].b)) begin n_err++;
                $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, ref_lat(tv[i].f3, tv[i].a, tv[i].b)); end
            n_cmp++; if (!bok) begin n_err++; $display("FAIL dir%0d_busy: got low before done expected high", i); end
            n_cmp++; if (ib !== 1'b0 || id !== 1'b0) begin n_err++;
                $display("FAIL dir%0d_after_done: got busy=%b done=%b expected 0 0", i, ib, id); end
        end
    endtask

    task automatic test_random_back_to_back();
        int lat; logic [31:0] res, rp, a, b; logic [2:0] f3; bit bok; logic bp, ib, id;
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom);
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 50); end
                3: begin a = -$urandom_range(0, 1000); b = -$urandom_range(1, 50); end
                default: ;
            endcase
            run_op(f3, a, b, D_NONE, -5, lat, res, bok, bp, rp, ib, id);
            n_cmp++; if (res !== ref_op(f3, a, b)) begin n_err++;
                $display("FAIL rnd%0d_result f3=%b a=%h b=%h: got %h expected %h", i, f3, a, b, res, ref_op(f3, a, b)); end
            n_cmp++; if (lat != ref_lat(f3, a, b) || !bok) begin n_err++;
                $display("FAIL rnd%0d_timing: got lat=%0d busy_ok=%0d expected lat=%0d busy_ok=1", i, lat, bok, ref_lat(f3, a, b)); end
        end
    endtask

    task automatic test_restart_ignored();
        int lat; logic [31:0] res, rp; bit bok; logic bp, ib, id;
        run_op(3'b000, 32'd7, 32'hFFFFFFFD, D_START, 10, lat, res, bok, bp, rp, ib, id);
        n_cmp++; if (res !== 32'hFFFFFFEB) begin n_err++; $display("FAIL restart_result: got %h expected FFFFFFEB", res); end
        n_cmp++; if (lat != LAT) begin n_err++; $display("FAIL restart_latency: got %0d expected %0d", lat, LAT); end
        // start presented in the DONE cycle of a divide-by-zero must not launch anything
        run_op(3'b101, 32'd5, 32'd0, D_START, LAT_SP, lat, res, bok, bp, rp, ib, id);
        n_cmp++; if (res !== 32'hFFFFFFFF || lat != LAT_SP) begin n_err++;
            $display("FAIL start_in_done_op: got %h lat=%0d expected FFFFFFFF lat=%0d", res, lat, LAT_SP); end
        n_cmp++; if (ib !== 1'b0) begin n_err++; $display("FAIL start_in_done_busy: got %b expected 0", ib); end
    endtask

    task automatic test_flush();
        int lat; logic [31:0] res, rp; bit bok; logic bp, ib, id;
        run_op(3'b101, 32'd100, 32'd7, D_NONE, -5, lat, res, bok, bp, rp, ib, id);
        run_op(3'b011, $urandom, $urandom, D_FLUSH, 10, lat, res, bok, bp, rp, ib, id);
        n_cmp++; if (lat != 0) begin n_err++; $display("FAIL flush_no_done: got done at %0d expected none", lat); end
        n_cmp++; if (bp !== 1'b0) begin n_err++; $display("FAIL flush_busy: got %b expected 0", bp); end
        n_cmp++; if (res !== 32'd14) begin n_err++; $display("FAIL flush_result: got %h expected 0000000e", res); end
        flush = 1'b1;
        repeat (2) @(posedge clk);
        #1; flush = 1'b0;
        n_cmp++; if (busy !== 1'b0 || result !== 32'd14) begin n_err++;
            $display("FAIL flush_idle: got busy=%b result=%h expected 0 0000000e", busy, result); end
        run_op(3'b111, 32'd100, 32'd7, D_FLUSH, 0, lat, res, bok, bp, rp, ib, id);
        n_cmp++; if (res !== 32'd2 || lat != LAT) begin n_err++;
            $display("FAIL flush_with_start: got %h lat=%0d expected 00000002 lat=%0d", res, lat, LAT); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] res, rp; bit bok; logic bp, ib, id;
        run_op(3'b000, $urandom | 32'h1, $urandom | 32'h1, D_RESET, 20, lat, res, bok, bp, rp, ib, id);
        n_cmp++; if (lat != 0) begin n_err++; $display("FAIL reset_mid_no_done: got done at %0d expected none", lat); end
        n_cmp++; if (bp !== 1'b0 || rp !== '0) begin n_err++;
            $display("FAIL reset_mid_state: got busy=%b result=%h expected 0 00000000", bp, rp); end
        run_op(3'b100, 32'hFFFFFFF9, 32'd2, D_NONE, -5, lat, res, bok, bp, rp, ib, id);
        n_cmp++; if (res !== 32'hFFFFFFFD || lat != LAT || !bok) begin n_err++;
            $display("FAIL reset_mid_recover: got %h lat=%0d expected FFFFFFFD lat=%0d", res, lat, LAT); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random_back_to_back();
        test_restart_ignored();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
